// File: rtl/spi_slave_param.sv
// -----------------------------------------------------------------------------
// spi_slave_param
//
// Parametrised SPI slave: configurable word width, any CPOL/CPHA mode and
// multi-word frames. SCK, SSEL and MOSI are asynchronous to clk and pass
// through a SYNC_STAGES-deep synchroniser before use. The host side is fully
// synchronous to clk.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   SCK, SSEL, MOSI SPI inputs from the master (SSEL active low)
//   MISO, miso_oe   slave data out and its output enable
//   rx_data/rx_valid   last complete received word, one-cycle valid pulse
//   tx_data/tx_valid   next word to transmit
//   tx_load         pulse when a transmit word is captured (or FILL used)
//   tx_underrun     pulse when FILL is used because tx_valid was low
//   frame_start     pulse on synchronised SSEL falling edge
//   frame_end       pulse on synchronised SSEL rising edge
//   frame_partial   with frame_end: the frame ended mid-word
//   word_index      words completed in the current frame (saturating)
// -----------------------------------------------------------------------------
module spi_slave_param #(
   parameter int                    WORD_WIDTH  = 8,
   parameter bit                    CPOL        = 1'b0,
   parameter bit                    CPHA        = 1'b0,
   parameter int                    SYNC_STAGES = 2,
   parameter int                    CNT_W       = 8,
   parameter logic [WORD_WIDTH-1:0] FILL        = '1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  SCK,
   input  logic                  SSEL,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic                  miso_oe,
   output logic [WORD_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic [WORD_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_load,
   output logic                  tx_underrun,
   output logic                  frame_start,
   output logic                  frame_end,
   output logic                  frame_partial,
   output logic [CNT_W-1:0]      word_index
);

   localparam int                BC_W        = $clog2(WORD_WIDTH);
   localparam logic [BC_W-1:0]   LAST_BIT    = BC_W'(WORD_WIDTH - 1);
   // Mode 0 and mode 3 sample on rising SCK, modes 1 and 2 on falling SCK.
   localparam bit                SAMPLE_RISE = (CPOL == CPHA);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      LOCKOUT = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sck_sync, ssel_sync, mosi_sync;
   logic                   sck_d, ssel_d;
   logic [SYNC_STAGES:0]   warm;
   logic                   sck_s, ssel_s, mosi_s, ready;
   logic                   sck_rise, sck_fall, ssel_rise, ssel_fall;
   logic                   sample_edge, shift_edge;
   logic                   start_c, end_c, sample_act, shift_act, completing, load_c;

   logic [BC_W-1:0]        bit_cnt;
   logic [WORD_WIDTH-2:0]  rx_shift;
   logic [WORD_WIDTH-1:0]  tx_shift;
   logic                   word_done_p0;
   logic                   skip_shift;

   // ---- stage: input synchronisers and edge-detect flops ----
   // Preset to idle pin levels so reset release never looks like an edge.
   // warm fills with ones once the synchronisers hold real pin values, so
   // the LOCKOUT decision is not made on the preset levels.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_sync  <= {SYNC_STAGES{CPOL}};
         ssel_sync <= '1;
         mosi_sync <= '0;
         sck_d     <= CPOL;
         ssel_d    <= 1'b1;
         warm      <= '0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
         ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], SSEL};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sck_d     <= sck_s;
         ssel_d    <= ssel_s;
         warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign ssel_s = ssel_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign ready  = warm[SYNC_STAGES];

   assign sck_rise    = sck_s & ~sck_d;
   assign sck_fall    = ~sck_s & sck_d;
   assign ssel_rise   = ssel_s & ~ssel_d;
   assign ssel_fall   = ~ssel_s & ssel_d;
   assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
   assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

   // ---- stage: frame state machine ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= LOCKOUT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_c   = 1'b0;
      end_c     = 1'b0;
      case (state)
         LOCKOUT: if (ready && ssel_s && ssel_d) state_nxt = IDLE;
         IDLE: begin
            if (ssel_fall) begin
               state_nxt = ACTIVE;
               start_c   = 1'b1;
            end
         end
         ACTIVE: begin
            if (ssel_rise) begin
               state_nxt = IDLE;
               end_c     = 1'b1;
            end
         end
         default: state_nxt = LOCKOUT;
      endcase
   end

   assign sample_act = (state == ACTIVE) && sample_edge;
   assign shift_act  = (state == ACTIVE) && shift_edge;
   assign completing = sample_act && (bit_cnt == LAST_BIT);
   // Reload at frame start and on the cycle after each completed word, but
   // not once the frame has already been closed.
   assign load_c     = start_c || (word_done_p0 && (state == ACTIVE));

   // ---- stage: receive shifter (data only, no reset needed) ----
   always_ff @(posedge clk) begin
      if (sample_act) rx_shift <= {rx_shift[WORD_WIDTH-3:0], mosi_s};
   end

   // ---- stage: word completion, transmit load and host-side pulses ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt       <= '0;
         word_index    <= '0;
         word_done_p0  <= 1'b0;
         rx_valid      <= 1'b0;
         rx_data       <= '0;
         tx_shift      <= '0;
         skip_shift    <= 1'b0;
         tx_load       <= 1'b0;
         tx_underrun   <= 1'b0;
         frame_start   <= 1'b0;
         frame_end     <= 1'b0;
         frame_partial <= 1'b0;
      end else begin
         frame_start   <= start_c;
         frame_end     <= end_c;
         // A word finishing in the same cycle as deselect is complete.
         frame_partial <= end_c && (bit_cnt != '0) && !completing;
         word_done_p0  <= completing;
         rx_valid      <= word_done_p0;
         tx_load       <= load_c;
         tx_underrun   <= load_c && !tx_valid;

         if (completing) rx_data <= {rx_shift, mosi_s};

         if (start_c)         bit_cnt <= '0;
         else if (completing) bit_cnt <= '0;
         else if (sample_act) bit_cnt <= bit_cnt + BC_W'(1);

         if (start_c)
            word_index <= '0;
         else if (completing && (word_index != '1))
            word_index <= word_index + CNT_W'(1);

         // The first shift edge after a load must not disturb the freshly
         // loaded MSB: in CPHA=1 that is the leading edge of every word, in
         // CPHA=0 it is the trailing edge right after a word's last sample.
         if (load_c) begin
            tx_shift   <= tx_valid ? tx_data : FILL;
            skip_shift <= start_c ? CPHA : 1'b1;
         end else if (shift_act) begin
            if (!skip_shift) tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};
            skip_shift <= 1'b0;
         end
      end
   end

   assign MISO    = tx_shift[WORD_WIDTH-1];
   assign miso_oe = ~ssel_s;

endmodule

// File: tb/tb_spi_slave_param.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_param
//
// Directed bench for spi_slave_param: an 8-bit mode-0 instance (dut0) and a
// 16-bit mode-3 instance (dut3). Expected received words go into per-DUT
// queues when the master drives them; monitors pop and compare on rx_valid.
// -----------------------------------------------------------------------------
module tb_spi_slave_param;

   localparam int HP = 8;   // SCK half period and SSEL setup, in clk cycles

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic       sck0, ssel0, mosi0, miso0, oe0, rxv0, txv0, ld0, un0, fs0, fe0, fp0;
   logic [7:0] rxd0, txd0, wi0;

   logic        sck3, ssel3, mosi3, miso3, oe3, rxv3, txv3, ld3, un3, fs3, fe3, fp3;
   logic [15:0] rxd3, txd3;
   logic [7:0]  wi3;

   spi_slave_param #(.WORD_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
      .clk(clk), .reset(rst), .SCK(sck0), .SSEL(ssel0), .MOSI(mosi0),
      .MISO(miso0), .miso_oe(oe0), .rx_data(rxd0), .rx_valid(rxv0),
      .tx_data(txd0), .tx_valid(txv0), .tx_load(ld0), .tx_underrun(un0),
      .frame_start(fs0), .frame_end(fe0), .frame_partial(fp0), .word_index(wi0));

   spi_slave_param #(.WORD_WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
      .clk(clk), .reset(rst), .SCK(sck3), .SSEL(ssel3), .MOSI(mosi3),
      .MISO(miso3), .miso_oe(oe3), .rx_data(rxd3), .rx_valid(rxv3),
      .tx_data(txd3), .tx_valid(txv3), .tx_load(ld3), .tx_underrun(un3),
      .frame_start(fs3), .frame_end(fe3), .frame_partial(fp3), .word_index(wi3));

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  exp_q0[$];
   logic [15:0] exp_q3[$];

   int nrx0 = 0, nfs0 = 0, nfe0 = 0, nld0 = 0, nun0 = 0;
   int nrx3 = 0, nfs3 = 0, nfe3 = 0, nld3 = 0, nun3 = 0;
   logic part0 = 1'b0, part3 = 1'b0;
   int b_rx0, b_fs0, b_fe0, b_ld0, b_un0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap0();
      b_rx0 = nrx0; b_fs0 = nfs0; b_fe0 = nfe0; b_ld0 = nld0; b_un0 = nun0;
   endtask

   // Monitors: count pulses and score received words.
   always @(negedge clk) begin
      if (!rst) begin
         if (rxv0) begin
            nrx0++;
            check("rx0_expected", 32'(exp_q0.size() != 0), 32'd1);
            if (exp_q0.size() != 0) check("rx0_data", 32'(rxd0), 32'(exp_q0.pop_front()));
         end
         if (fs0) nfs0++;
         if (fe0) begin nfe0++; part0 = fp0; end
         if (ld0) nld0++;
         if (un0) nun0++;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (rxv3) begin
            nrx3++;
            check("rx3_expected", 32'(exp_q3.size() != 0), 32'd1);
            if (exp_q3.size() != 0) check("rx3_data", 32'(rxd3), 32'(exp_q3.pop_front()));
         end
         if (fs3) nfs3++;
         if (fe3) begin nfe3++; part3 = fp3; end
         if (ld3) nld3++;
         if (un3) nun3++;
      end
   end

   // Mode 0 master: MOSI set while SCK low, MISO captured at the rising edge.
   task automatic spi0_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi0 = tx[i];
         wait_clk(HP);
         rx[i] = miso0;
         sck0  = 1'b1;
         wait_clk(HP);
         sck0  = 1'b0;
      end
   endtask

   // Mode 3 master: drive on falling SCK, capture MISO at rising SCK and
   // confirm it is still unchanged a little after the rising edge.
   task automatic spi3_word(input logic [15:0] tx, output logic [15:0] rx, output int unstable);
      rx = '0;
      unstable = 0;
      for (int i = 15; i >= 0; i--) begin
         sck3  = 1'b0;
         mosi3 = tx[i];
         wait_clk(HP);
         rx[i] = miso3;
         sck3  = 1'b1;
         wait_clk(2);
         if (miso3 !== rx[i]) unstable++;
         wait_clk(HP - 2);
      end
   endtask

   logic [7:0]  m0a, m0b;
   logic [15:0] m3;
   int          unst;

   initial begin
      rst = 1'b1;
      sck0 = 1'b0; ssel0 = 1'b1; mosi0 = 1'b0; txv0 = 1'b1; txd0 = 8'h00;
      sck3 = 1'b1; ssel3 = 1'b1; mosi3 = 1'b0; txv3 = 1'b1; txd3 = 16'h0000;
      wait_clk(3);
      check("rst_rx_data0",  32'(rxd0), 32'h0);
      check("rst_rx_valid0", 32'(rxv0), 32'h0);
      check("rst_miso0",     32'(miso0), 32'h0);
      check("rst_oe0",       32'(oe0), 32'h0);
      check("rst_word_idx0", 32'(wi0), 32'h0);
      check("rst_fstart0",   32'(fs0), 32'h0);
      check("rst_rx_data3",  32'(rxd3), 32'h0);
      check("rst_miso3",     32'(miso3), 32'h0);
      check("rst_oe3",       32'(oe3), 32'h0);
      rst = 1'b0;
      wait_clk(6);

      // Single word, mode 0
      txd0 = 8'h5A; txv0 = 1'b1;
      snap0();
      ssel0 = 1'b0; wait_clk(HP);
      check("t1_oe", 32'(oe0), 32'h1);
      exp_q0.push_back(8'hEA);
      spi0_bits(8'hEA, 8, m0a);
      wait_clk(HP); ssel0 = 1'b1; wait_clk(HP);
      check("t1_miso",      32'(m0a), 32'h5A);
      check("t1_fstart",    32'(nfs0 - b_fs0), 32'd1);
      check("t1_rx_pulses", 32'(nrx0 - b_rx0), 32'd1);
      check("t1_word_idx",  32'(wi0), 32'd1);
      check("t1_underrun",  32'(nun0 - b_un0), 32'd0);
      check("t1_fend",      32'(nfe0 - b_fe0), 32'd1);

      // Two back-to-back words
      txd0 = 8'hC3;
      snap0();
      ssel0 = 1'b0; wait_clk(HP);
      txd0 = 8'h3C;
      exp_q0.push_back(8'h00);
      exp_q0.push_back(8'h01);
      spi0_bits(8'h00, 8, m0a);
      spi0_bits(8'h01, 8, m0b);
      wait_clk(HP); ssel0 = 1'b1; wait_clk(HP);
      check("t2_miso_w0",   32'(m0a), 32'hC3);
      check("t2_miso_w1",   32'(m0b), 32'h3C);
      check("t2_rx_pulses", 32'(nrx0 - b_rx0), 32'd2);
      check("t2_tx_loads",  32'(nld0 - b_ld0), 32'd3);
      check("t2_fend",      32'(nfe0 - b_fe0), 32'd1);
      check("t2_partial",   32'(part0), 32'd0);
      check("t2_word_idx",  32'(wi0), 32'd2);

      // 16-bit mode 3
      txd3 = 16'h1234;
      ssel3 = 1'b0; wait_clk(HP);
      exp_q3.push_back(16'hBEEF);
      spi3_word(16'hBEEF, m3, unst);
      wait_clk(HP); ssel3 = 1'b1; wait_clk(HP);
      check("t3_miso",      32'(m3), 32'h1234);
      check("t3_stable",    32'(unst), 32'd0);
      check("t3_rx_pulses", 32'(nrx3), 32'd1);
      check("t3_fstart",    32'(nfs3), 32'd1);
      check("t3_fend",      32'(nfe3), 32'd1);
      check("t3_partial",   32'(part3), 32'd0);
      check("t3_underrun",  32'(nun3), 32'd0);
      check("t3_tx_loads",  32'(nld3), 32'd2);
      check("t3_word_idx",  32'(wi3), 32'd1);

      // Underrun: tx_valid low
      txv0 = 1'b0; txd0 = 8'h00;
      snap0();
      ssel0 = 1'b0; wait_clk(HP);
      exp_q0.push_back(8'h81);
      spi0_bits(8'h81, 8, m0a);
      wait_clk(HP); ssel0 = 1'b1; wait_clk(HP);
      check("t4_miso",      32'(m0a), 32'hFF);
      check("t4_underruns", 32'(nun0 - b_un0), 32'd2);
      check("t4_tx_loads",  32'(nld0 - b_ld0), 32'd2);
      check("t4_rx_data",   32'(rxd0), 32'h81);
      txv0 = 1'b1;

      // Partial frame then a full one
      snap0();
      ssel0 = 1'b0; wait_clk(HP);
      spi0_bits(8'hF8, 5, m0a);
      wait_clk(HP); ssel0 = 1'b1; wait_clk(HP);
      check("t5_rx_pulses", 32'(nrx0 - b_rx0), 32'd0);
      check("t5_fend",      32'(nfe0 - b_fe0), 32'd1);
      check("t5_partial",   32'(part0), 32'd1);
      snap0();
      ssel0 = 1'b0; wait_clk(HP);
      exp_q0.push_back(8'hA5);
      spi0_bits(8'hA5, 8, m0a);
      wait_clk(HP); ssel0 = 1'b1; wait_clk(HP);
      check("t5_full_rx",   32'(nrx0 - b_rx0), 32'd1);
      check("t5_full_part", 32'(part0), 32'd0);

      // Reset mid-frame, then lockout
      ssel0 = 1'b0; wait_clk(HP);
      spi0_bits(8'hE0, 3, m0a);
      rst = 1'b1;
      wait_clk(2);
      check("t6_rst_rx_data", 32'(rxd0), 32'h0);
      check("t6_rst_word_idx", 32'(wi0), 32'h0);
      check("t6_rst_oe",      32'(oe0), 32'h0);
      check("t6_rst_miso",    32'(miso0), 32'h0);
      rst = 1'b0;
      snap0();
      wait_clk(HP);
      spi0_bits(8'hFF, 8, m0a);
      wait_clk(HP); ssel0 = 1'b1; wait_clk(HP);
      check("t6_lock_rx",     32'(nrx0 - b_rx0), 32'd0);
      check("t6_lock_fend",   32'(nfe0 - b_fe0), 32'd0);
      check("t6_lock_fstart", 32'(nfs0 - b_fs0), 32'd0);
      ssel0 = 1'b0; wait_clk(HP);
      exp_q0.push_back(8'h3C);
      spi0_bits(8'h3C, 8, m0a);
      wait_clk(HP); ssel0 = 1'b1; wait_clk(HP);
      check("t6_rx_data",   32'(rxd0), 32'h3C);
      check("t6_rx_pulses", 32'(nrx0 - b_rx0), 32'd1);

      check("rx0_drained", 32'(exp_q0.size()), 32'd0);
      check("rx3_drained", 32'(exp_q3.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised successor to the fixed 8-bit mode-0 SPI slave.
- Adds configurable word width, all four CPOL/CPHA modes and multi-word frames.
- Adds a transmit-data handshake with underrun signalling, and frame start/end/partial reporting.
- All SPI pins are asynchronous to clk and are synchronised internally; the host-side interface is fully synchronous to clk.

Parameters:
WORD_WIDTH, 8, bits per SPI word, MSB first, legal range 4..32
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge
SYNC_STAGES, 2, flip-flop depth of the SCK/SSEL/MOSI synchronisers, minimum 2
CNT_W, 8, width of word_index, saturating
FILL, all ones, word transmitted when tx_valid is low at load time

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
SCK  input  1  SPI clock from master
SSEL  input  1  slave select, active low
MOSI  input  1  master-out data
MISO  output  1  slave-out data
miso_oe  output  1  high while synchronised SSEL is low
rx_data  output  WORD_WIDTH  last complete received word
rx_valid  output  1  one-cycle pulse when rx_data updates
tx_data  input  WORD_WIDTH  next word to transmit
tx_valid  input  1  tx_data is valid
tx_load  output  1  one-cycle pulse when tx_data is captured or FILL is substituted
tx_underrun  output  1  one-cycle pulse when FILL is substituted
frame_start  output  1  one-cycle pulse on synchronised SSEL falling edge
frame_end  output  1  one-cycle pulse on synchronised SSEL rising edge
frame_partial  output  1  valid with frame_end: bit counter was nonzero at deselect
word_index  output  CNT_W  words completed in current frame, saturates at all ones

Behaviour:
- Reset values:
  - MISO = 0, miso_oe = 0, rx_data = 0.
  - All pulse outputs = 0, word_index = 0.
  - Synchronisers are preset to the idle levels: SSEL = 1, SCK = CPOL, MOSI = 0.
- Synchronisation and edge detection:
  - Each SPI input passes through SYNC_STAGES flops plus one edge-detect flop.
  - Sample edge: rising synchronised SCK when CPOL xor CPHA = 0, otherwise falling.
  - Shift edge is the opposite polarity.
- Timing requirements on the master:
  - SCK high and low times each ≥ SYNC_STAGES+2 clk periods.
  - SSEL setup to first SCK edge ≥ SYNC_STAGES+2 clk periods.
- States: IDLE, ACTIVE, LOCKOUT.
  - IDLE -> ACTIVE on synchronised SSEL falling edge.
    - Pulse frame_start.
    - Clear the bit counter and word_index.
    - Perform a tx load.
  - ACTIVE -> IDLE on synchronised SSEL rising edge.
    - Pulse frame_end.
    - frame_partial = (bit counter != 0); partial bits are discarded and produce no rx_valid.
  - After reset: if synchronised SSEL is low, enter LOCKOUT; otherwise enter IDLE.
    - LOCKOUT ignores all SCK edges and produces no pulses.
    - LOCKOUT -> IDLE when SSEL goes high; no frame_end is produced.
- Receive path:
  - On each sample edge in ACTIVE, shift the synchronised MOSI into the rx shift register LSB and increment the bit counter.
  - On the WORD_WIDTH-th sample edge:
    - rx_data <= completed word; rx_valid pulses on the next clk cycle.
    - The bit counter wraps to 0 and word_index increments, saturating.
  - rx_valid latency: high during the clk cycle that begins SYNC_STAGES+2 clk rising edges after the first edge at which SCK shows the sample level.
  - rx_valid has no backpressure; the host must consume rx_data within one word time.
- Transmit path:
  - A tx load occurs at SSEL assertion and again on the cycle after each word completes.
  - At a load:
    - If tx_valid = 1, the shift register <= tx_data.
    - Otherwise the shift register <= FILL and tx_underrun pulses.
    - tx_load pulses in the same cycle as the capture.
  - MISO equals the shift register MSB.
  - CPHA = 0: the MSB appears at load time; the register shifts left on each shift edge, except the shift edge that follows the last sample of a word, which is replaced by the load.
  - CPHA = 1: the first shift edge of each word performs no shift, so the loaded MSB is presented; later shift edges shift left.
- Simultaneous events:
  - SSEL rising in the same cycle as word completion: rx_valid still pulses and frame_partial = 0.
  - A word completing while word_index is saturated still pulses rx_valid.
- Reset asserted mid-frame:
  - All outputs return to reset values immediately.
  - LOCKOUT rules then apply.

Test Plan:
- WORD_WIDTH=8, mode 0, tx 0x5A valid; SSEL low, send MOSI 0xEA -> frame_start once; MISO bits 0,1,0,1,1,0,1,0; rx_valid exactly one cycle with rx_data=0xEA; word_index=1; no underrun.
- WORD_WIDTH=8, mode 0, two back-to-back words 0x00 then 0x01, tx 0xC3 then 0x3C -> two rx_valid pulses (0x00, 0x01); two tx_load pulses after frame start; frame_end with partial=0; word_index=2.
- WORD_WIDTH=16, CPOL=1, CPHA=1, send 0xBEEF with tx 0x1234 -> rx_data=0xBEEF; MISO shows 0x1234 MSB first, changing on falling SCK and stable on rising SCK.
- Mode 0, tx_valid low, send 0x81 -> tx_underrun pulses at load; MISO all ones; rx_data=0x81.
- Mode 0, 5 bits sent then SSEL high -> no rx_valid; frame_end with frame_partial=1; next full frame of 0xA5 is received correctly.
- Assert reset after 3 bits with SSEL held low, release, clock 8 more bits -> no rx_valid and no frame_end; after SSEL high then low, a full frame of 0x3C gives rx_data=0x3C.
